// File: rtl/op_dispatcher_pkg.sv
// Shared definitions for the opcode dispatcher and the calculator datapath blocks
// that reuse its opcode/latency widths and state encoding.
package op_dispatcher_pkg;

  localparam int OP_W_DEF  = 4;
  localparam int LAT_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } disp_state_t;

endpackage

// File: rtl/onehot_decode.sv
// Binary-to-one-hot decoder with enable; all outputs are zero when disabled.
module onehot_decode #(
  parameter int OP_W = 4
) (
  input  logic                 en,
  input  logic [OP_W-1:0]      code,
  output logic [2**OP_W-1:0]   onehot
);

  // NOTE: assigning a default before any conditional write keeps this purely
  // combinational; without it synthesis infers a latch for unwritten bits.
  always_comb begin
    onehot = '0;
    if (en) onehot[code] = 1'b1;
  end

endmodule

// File: rtl/op_dispatcher.sv
// Accepts one opcode at a time, drives its one-hot select for opLatency+1 cycles,
// then pulses done (or pulses illegal if the opcode was masked off at accept).
module op_dispatcher
  import op_dispatcher_pkg::*;
#(
  parameter int OP_W  = OP_W_DEF,
  parameter int N_OPS = 2**OP_W,
  parameter int LAT_W = LAT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             opValid,
  input  logic [OP_W-1:0]  opCode,
  input  logic [LAT_W-1:0] opLatency,
  input  logic [N_OPS-1:0] opMask,
  input  logic             opAbort,
  output logic             opReady,
  output logic [N_OPS-1:0] hotselect,
  output logic             done,
  output logic             illegal
);

  disp_state_t      state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic [OP_W-1:0]  code_q, code_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    case (state_q)
      ST_IDLE: begin
        // opMask is consulted only here, so later mask changes cannot affect
        // an operation already in flight.
        if (opValid) begin
          if (opMask[opCode]) begin
            state_d = ST_BUSY;
            code_d  = opCode;
            cnt_d   = opLatency;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_BUSY: begin
        if (opAbort)           state_d = ST_IDLE;
        else if (cnt_q == '0)  state_d = ST_DONE;
        else                   cnt_d   = cnt_q - LAT_W'(1);
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign opReady = (state_q == ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign illegal = (state_q == ST_ERR);

  onehot_decode #(
    .OP_W (OP_W)
  ) u_decode (
    .en     (state_q == ST_BUSY),
    .code   (code_q),
    .onehot (hotselect)
  );

endmodule

// File: tb/tb_op_dispatcher.sv
// Self-checking bench: directed scenarios plus random traffic, compared every cycle
// against a transaction-level schedule of expected outputs.
module tb_op_dispatcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        opValid;
  logic [3:0]  opCode;
  logic [3:0]  opLatency;
  logic [15:0] opMask;
  logic        opAbort;
  logic        opReady;
  logic [15:0] hotselect;
  logic        done;
  logic        illegal;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  op_dispatcher dut (
    .clk       (clk),
    .rst       (rst),
    .opValid   (opValid),
    .opCode    (opCode),
    .opLatency (opLatency),
    .opMask    (opMask),
    .opAbort   (opAbort),
    .opReady   (opReady),
    .hotselect (hotselect),
    .done      (done),
    .illegal   (illegal)
  );

  typedef struct packed {
    logic        ready;
    logic [15:0] hot;
    logic        dn;
    logic        ill;
  } obs_t;

  localparam obs_t IDLE_OBS = '{ready: 1'b1, hot: 16'h0, dn: 1'b0, ill: 1'b0};

  // Model: cur is what the outputs must show this cycle; sched holds the
  // outputs of the cycles still to come for the transaction in flight.
  obs_t cur = IDLE_OBS;
  obs_t sched[$];
  logic accepted;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_edge();
    obs_t o;
    accepted = 1'b0;
    if (rst) begin
      sched.delete();
      cur = IDLE_OBS;
    end else if (cur.hot != 16'h0 && opAbort) begin
      sched.delete();
      cur = IDLE_OBS;
    end else if (cur.ready && opValid) begin
      accepted = 1'b1;
      if (opMask[opCode]) begin
        o = '{ready: 1'b0, hot: 16'h1 << opCode, dn: 1'b0, ill: 1'b0};
        for (int i = 0; i <= int'(opLatency); i++) sched.push_back(o);
        sched.push_back('{ready: 1'b0, hot: 16'h0, dn: 1'b1, ill: 1'b0});
      end else begin
        sched.push_back('{ready: 1'b0, hot: 16'h0, dn: 1'b0, ill: 1'b1});
      end
      cur = sched.pop_front();
    end else begin
      cur = (sched.size() != 0) ? sched.pop_front() : IDLE_OBS;
    end
  endtask

  // Inputs are driven at the falling edge; outputs are checked 1 ns after the rising edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check("outputs", {13'd0, opReady, hotselect, done, illegal}, {13'd0, cur});
    check("exclusive", {31'd0, (done & illegal) | ((done | illegal) & (hotselect != 16'h0))}, 32'd0);
    check("onehot", {31'd0, $countones(hotselect) > 1}, 32'd0);
    @(negedge clk);
  endtask

  task automatic issue(input logic [3:0] code, input logic [3:0] lat, input logic [15:0] mask);
    opValid = 1'b1; opCode = code; opLatency = lat; opMask = mask;
    cycle();
    opValid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  int          busy_seen;
  logic [15:0] bits_seen;
  int          code_next;

  initial begin
    rst = 1'b1; opValid = 1'b0; opCode = '0; opLatency = '0; opMask = 16'hFFFF; opAbort = 1'b0;
    @(negedge clk);
    cycle();
    check("reset_ready", {31'd0, opReady}, 32'd1);
    check("reset_hot", {16'd0, hotselect}, 32'd0);
    rst = 1'b0;
    idle_cycles(1);

    // opCode 3, latency 0: one select cycle, then done, then ready.
    issue(4'd3, 4'd0, 16'hFFFF);
    check("op3_hot", {16'd0, hotselect}, 32'h0008);
    cycle();
    check("op3_done", {31'd0, done}, 32'd1);
    cycle();
    check("op3_ready", {31'd0, opReady}, 32'd1);

    // opCode 15, latency 5: six select cycles, with inputs wiggled mid-flight.
    issue(4'd15, 4'd5, 16'hFFFF);
    opCode = 4'd1; opLatency = 4'd0; opMask = 16'h0; opValid = 1'b1;
    idle_cycles(6);
    check("op15_done", {31'd0, done}, 32'd1);
    opValid = 1'b0; opMask = 16'hFFFF;
    idle_cycles(1);

    // Masked opcode 2: illegal pulse, no select, no done.
    issue(4'd2, 4'd4, 16'hFFFB);
    check("masked_illegal", {31'd0, illegal}, 32'd1);
    idle_cycles(2);

    // opCode 7, latency 9, abort on the third select cycle.
    issue(4'd7, 4'd9, 16'hFFFF);
    idle_cycles(2);
    opAbort = 1'b1;
    cycle();
    check("abort_hot", {16'd0, hotselect}, 32'd0);
    check("abort_ready", {31'd0, opReady}, 32'd1);
    idle_cycles(2);
    opAbort = 1'b0;

    // Reset mid-operation, with opValid held high through the reset cycle.
    issue(4'd1, 4'd8, 16'hFFFF);
    idle_cycles(3);
    rst = 1'b1; opValid = 1'b1; opAbort = 1'b1;
    cycle();
    check("rst_mid_hot", {16'd0, hotselect}, 32'd0);
    check("rst_mid_ready", {31'd0, opReady}, 32'd1);
    rst = 1'b0; opValid = 1'b0; opAbort = 1'b0;
    idle_cycles(2);

    // Back-to-back sweep of all opcodes with opValid held high.
    busy_seen = 0; bits_seen = '0; code_next = 0;
    opValid = 1'b1; opLatency = 4'd0; opMask = 16'hFFFF;
    for (int i = 0; i < 200 && code_next < 16; i++) begin
      opCode = 4'(code_next);
      cycle();
      if (accepted) code_next++;
      if (hotselect != 16'h0) begin
        busy_seen++;
        bits_seen |= hotselect;
      end
    end
    opValid = 1'b0;
    idle_cycles(3);
    check("sweep_accepts", code_next, 32'd16);
    check("sweep_busy_cycles", busy_seen, 32'd16);
    check("sweep_bits", {16'd0, bits_seen}, 32'h0000FFFF);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 49) == 0);
      opValid   = ($urandom_range(0, 2) != 0);
      opCode    = 4'($urandom);
      opLatency = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
      opMask    = 16'($urandom) | 16'($urandom);
      opAbort   = ($urandom_range(0, 15) == 0);
      cycle();
    end
    rst = 1'b0; opValid = 1'b0; opAbort = 1'b0;
    idle_cycles(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/op_dispatcher.md
OP_DISPATCHER -- requirements
Module: op_dispatcher

Interface
REQ-001 Parameter OP_W, default 4, opcode width in bits.
REQ-002 Parameter N_OPS, default 2**OP_W, number of one-hot select lines; fixed at 2**OP_W.
REQ-003 Parameter LAT_W, default 4, width of the per-operation latency field.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 opValid  input  1  requester presents an opcode.
REQ-007 opCode  input  OP_W  operation to dispatch.
REQ-008 opLatency  input  LAT_W  extra busy cycles for this operation, sampled with opCode.
REQ-009 opMask  input  N_OPS  bit i set = operation i implemented/enabled.
REQ-010 opAbort  input  1  cancels an operation in progress.
REQ-011 opReady  output  1  dispatcher can accept an opcode.
REQ-012 hotselect  output  N_OPS  one-hot select of the active operation, else all zero.
REQ-013 done  output  1  one-cycle pulse, operation completed normally.
REQ-014 illegal  output  1  one-cycle pulse, accepted opcode was masked off.

Function
REQ-015 States IDLE, BUSY, DONE, ERR; all outputs registered or decoded from registered state only.
REQ-016 Accept = opValid & opReady at a rising edge; opReady is 1 only in IDLE.
REQ-017 IDLE, accept, opMask[opCode]=1: next BUSY, latch opCode, counter <= opLatency.
REQ-018 IDLE, accept, opMask[opCode]=0: next ERR; no select asserted.
REQ-019 BUSY: hotselect = one-hot of latched opCode (bit opCode set, all others 0); exactly one bit high.
REQ-020 BUSY, counter=0: next DONE; counter>0: counter decrements by 1, stay BUSY.
REQ-021 hotselect high for exactly opLatency+1 cycles, first cycle = cycle after accept; opLatency=0 gives one cycle.
REQ-022 DONE: hotselect=0, done=1, opReady=0, for one cycle; next IDLE.
REQ-023 ERR: illegal=1, hotselect=0, opReady=0, for one cycle; next IDLE.
REQ-024 opAbort in BUSY: next IDLE, hotselect=0 next cycle, no done pulse; abort wins over counter=0.
REQ-025 opAbort in IDLE, DONE, ERR: ignored.
REQ-026 opCode, opLatency, opMask changes while not IDLE: ignored; opMask sampled only at accept.
REQ-027 opValid held high continuously: next accept occurs in the first IDLE cycle after DONE/ERR (minimum 3-cycle issue interval for latency 0).
REQ-028 done and illegal never both high; neither high in the same cycle as hotselect nonzero.

Reset
REQ-029 rst high at a rising edge: state IDLE, counter 0, latched opcode 0, regardless of current state.
REQ-030 Outputs after reset: opReady=1, hotselect=0, done=0, illegal=0; rst mid-BUSY drops hotselect next cycle with no done.
REQ-031 rst has priority over opValid and opAbort in the same cycle.

Structure
REQ-032 Shared package holds the state enumeration and OP_W/LAT_W defaults for reuse by calculator datapath blocks.
REQ-033 One sub-module, onehot_decode (parametrised OP_W -> 2**OP_W combinational decoder with enable), produces hotselect; FSM and counter stay in op_dispatcher.

Verification
REQ-034 Reset, then opCode=3, opLatency=0, opMask=all ones, one-cycle opValid -> hotselect=16'h0008 for 1 cycle, done next cycle, opReady back the cycle after.
REQ-035 opCode=15, opLatency=5 -> hotselect=16'h8000 for exactly 6 cycles, opReady=0 throughout, then done pulse.
REQ-036 opMask=16'hFFFB, opCode=2 -> illegal pulse one cycle after accept, hotselect stays 0, no done.
REQ-037 opCode=7, opLatency=9, opAbort at 3rd BUSY cycle -> hotselect=0 next cycle, opReady=1, no done; opAbort in IDLE changes nothing.
REQ-038 rst asserted mid-BUSY (opLatency=8) -> next cycle all outputs at reset values; opValid held high during rst not accepted.
REQ-039 Exhaustive sweep opCode 0..15 with opValid held high -> each hotselect bit seen once in order, exactly one bit per BUSY cycle, 3-cycle issue interval.
